// File: rtl/perceptron_trainer.sv
// Perceptron learning sequencer: load sample, trigger neuron, classify, apply update on a miss.
// Latency: match -> done 2 cycles after neuron_done; mismatch -> weight_write +3, done +4.
// No backpressure: start is only accepted in IDLE, requests while busy are dropped.
module perceptron_trainer #(
    parameter int LR_SHIFT     = 4,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic        target,
    input  logic        clear_cnt,
    input  logic [15:0] weight1,
    input  logic [15:0] weight2,
    input  logic [15:0] neuron_result,
    input  logic        neuron_done,
    output logic [15:0] data_in1,
    output logic [15:0] data_in2,
    output logic        input_write,
    output logic        neuron_start,
    output logic [15:0] weight1_new,
    output logic [15:0] weight2_new,
    output logic        weight_write,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        timeout,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_IN, S_START, S_WAIT_RES, S_EVAL, S_UPDATE, S_WRITE_W, S_FINISH
    } state_t;

    localparam int CW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(DONE_TIMEOUT - 1);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic           target_r;
    logic [15:0]    result_r;
    logic           mismatch;
    logic signed [15:0] d1;
    logic signed [15:0] d2;

    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    // Sign bit set means class -1; a zero result counts as +1.
    assign mismatch = (result_r[15] == target_r);
    assign d1       = $signed(data_in1) >>> LR_SHIFT;
    assign d2       = $signed(data_in2) >>> LR_SHIFT;

    function automatic logic [15:0] sat_step(input logic [15:0] w, input logic [15:0] d,
                                             input logic add);
        logic [16:0] s;
        s = add ? ({w[15], w} + {d[15], d}) : ({w[15], w} - {d[15], d});
        if (s[16] != s[15])
            return s[16] ? 16'h8000 : 16'h7FFF;
        return s[15:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (start) state_nxt = S_LOAD_IN;
            S_LOAD_IN:  state_nxt = S_START;
            S_START:    state_nxt = S_WAIT_RES;
            S_WAIT_RES: begin
                if (neuron_done)
                    state_nxt = S_EVAL;
                else if (tmo_hit)
                    state_nxt = S_FINISH;
            end
            S_EVAL:     state_nxt = mismatch ? S_UPDATE : S_FINISH;
            S_UPDATE:   state_nxt = S_WRITE_W;
            S_WRITE_W:  state_nxt = S_FINISH;
            S_FINISH:   state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        input_write  = (state == S_LOAD_IN);
        neuron_start = (state == S_START);
        weight_write = (state == S_WRITE_W);
        done         = (state == S_FINISH);
        busy         = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in1    <= '0;
            data_in2    <= '0;
            target_r    <= 1'b0;
            tmo_cnt     <= '0;
            result_r    <= '0;
            weight1_new <= '0;
            weight2_new <= '0;
            error       <= 1'b0;
            timeout     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                data_in1 <= x1;
                data_in2 <= x2;
                target_r <= target;
            end

            if (state == S_START)
                tmo_cnt <= '0;
            else if (state == S_WAIT_RES && !neuron_done && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (state == S_WAIT_RES && neuron_done)
                result_r <= neuron_result;

            if (state == S_UPDATE) begin
                weight1_new <= sat_step(weight1, d1, target_r);
                weight2_new <= sat_step(weight2, d2, target_r);
            end

            // Flags are latched on entry to FINISH so they are valid alongside done.
            if (state_nxt == S_FINISH && state != S_FINISH) begin
                error   <= (state == S_WRITE_W);
                timeout <= (state == S_WAIT_RES);
            end

            if (clear_cnt)
                err_cnt <= '0;
            else if (state == S_FINISH && error && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: directed table plus randomized samples against an arithmetic model.
module tb_perceptron_trainer;
    localparam int LR  = 4;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, target, clear_cnt, neuron_done;
    logic [15:0] x1, x2, weight1, weight2, neuron_result;
    logic [15:0] data_in1, data_in2, weight1_new, weight2_new, err_cnt;
    logic        input_write, neuron_start, weight_write, busy, done, error, timeout;

    perceptron_trainer #(.LR_SHIFT(LR), .DONE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x1(x1), .x2(x2), .target(target),
        .clear_cnt(clear_cnt), .weight1(weight1), .weight2(weight2),
        .neuron_result(neuron_result), .neuron_done(neuron_done),
        .data_in1(data_in1), .data_in2(data_in2), .input_write(input_write),
        .neuron_start(neuron_start), .weight1_new(weight1_new), .weight2_new(weight2_new),
        .weight_write(weight_write), .busy(busy), .done(done), .error(error),
        .timeout(timeout), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x1, x2;
        logic        tgt;
        logic [15:0] w1, w2, res;
        int          dly;
        bit          give;
        bit          exp_err, exp_tmo;
        logic [15:0] exp_w1, exp_w2;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_cnt = 0;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic t, logic [15:0] w1,
                                logic [15:0] w2, logic [15:0] r, int dly, bit give,
                                bit ee, bit et, logic [15:0] ew1, logic [15:0] ew2);
        vec_t v;
        v.x1 = a; v.x2 = b; v.tgt = t; v.w1 = w1; v.w2 = w2; v.res = r;
        v.dly = dly; v.give = give; v.exp_err = ee; v.exp_tmo = et;
        v.exp_w1 = ew1; v.exp_w2 = ew2;
        return v;
    endfunction

    // Perceptron rule in plain integer arithmetic with clamping to the Q8.8 range.
    function automatic logic [15:0] upd(logic [15:0] w, logic [15:0] x, logic tgt);
        int wi, d, s;
        wi = $signed(w);
        d  = $signed(x);
        d  = d >>> LR;
        s  = tgt ? wi + d : wi - d;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic vec_t model(vec_t v);
        bit y_pos;
        y_pos     = ($signed(v.res) >= 0);
        v.exp_tmo = !v.give;
        v.exp_err = v.give && (y_pos != v.tgt);
        v.exp_w1  = upd(v.w1, v.x1, v.tgt);
        v.exp_w2  = upd(v.w2, v.x2, v.tgt);
        return v;
    endfunction

    task automatic run(input vec_t v, input bit inject, input bit clr, input string tag);
        int iw_c = -1, ns_c = -1, ww_c = -1, dn_c = -1, n, exp_dn;
        logic [15:0] w1n = '0, w2n = '0, dx1 = '0;
        logic er = 1'b0, to = 1'b0;
        n = 3 + v.dly;
        @(negedge clk);
        x1 = v.x1; x2 = v.x2; target = v.tgt; weight1 = v.w1; weight2 = v.w2;
        neuron_result = v.res; start = 1'b1;
        for (int c = 1; c <= TMO + 20; c++) begin
            @(negedge clk);
            if (c == 1) chk({tag, ".busy"}, 32'(busy), 32'd1);
            if (input_write && iw_c < 0) iw_c = c;
            if (neuron_start && ns_c < 0) ns_c = c;
            if (weight_write) begin ww_c = c; w1n = weight1_new; w2n = weight2_new; end
            start = 1'b0; neuron_done = 1'b0;
            if (done) begin dn_c = c; er = error; to = timeout; dx1 = data_in1; break; end
            if (v.give && c == n) neuron_done = 1'b1;
            if (inject && c == 3) begin start = 1'b1; x1 = ~v.x1; end
        end
        exp_dn = !v.give ? 3 + TMO : (v.exp_err ? n + 4 : n + 2);
        chk({tag, ".iw_cyc"}, 32'(iw_c), 32'd1);
        chk({tag, ".ns_cyc"}, 32'(ns_c), 32'd2);
        chk({tag, ".done_cyc"}, 32'(dn_c), 32'(exp_dn));
        chk({tag, ".error"}, 32'(er), 32'(v.exp_err));
        chk({tag, ".timeout"}, 32'(to), 32'(v.exp_tmo));
        chk({tag, ".data_in1"}, 32'(dx1), 32'(v.x1));
        chk({tag, ".ww_cyc"}, 32'(ww_c), v.exp_err ? 32'(n + 3) : 32'hFFFF_FFFF);
        if (v.exp_err) begin
            chk({tag, ".w1_new"}, 32'(w1n), 32'(v.exp_w1));
            chk({tag, ".w2_new"}, 32'(w2n), 32'(v.exp_w2));
            if (exp_cnt < 65535) exp_cnt++;
        end
        if (clr) begin clear_cnt = 1'b1; exp_cnt = 0; end
        @(negedge clk);
        clear_cnt = 1'b0;
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dones;
        vec_t v;
        rst_n = 1'b0; start = 1'b0; target = 1'b0; clear_cnt = 1'b0; neuron_done = 1'b0;
        x1 = '0; x2 = '0; weight1 = '0; weight2 = '0; neuron_result = '0;
        tbl[0] = mk(16'h0100, 16'hFF00, 1, 16'h0080, 16'h0040, 16'h0100, 0, 1, 0, 0, 0, 0);
        tbl[1] = mk(16'h0100, 16'hFF00, 1, 16'h0080, 16'h0040, 16'h8000, 2, 1, 1, 0, 16'h0090, 16'h0030);
        tbl[2] = mk(16'h7FFF, 16'h0000, 1, 16'h7FF0, 16'h0000, 16'hFFFF, 1, 1, 1, 0, 16'h7FFF, 16'h0000);
        tbl[3] = mk(16'h7FFF, 16'h0000, 0, 16'h8010, 16'h0000, 16'h0000, 0, 1, 1, 0, 16'h8000, 16'h0000);
        tbl[4] = mk(16'h0000, 16'h8000, 1, 16'h0000, 16'h8000, 16'h8001, 4, 1, 1, 0, 16'h0000, 16'h8000);
        tbl[5] = mk(16'h1234, 16'h0010, 0, 16'h0000, 16'h0000, 16'h8000, 3, 1, 0, 0, 0, 0);
        tbl[6] = mk(16'h0100, 16'h0100, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 0);

        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.strobes", 32'({input_write, neuron_start, weight_write, done, error, timeout}), 32'd0);
        chk("rst.err_cnt", 32'(err_cnt), 32'd0);
        chk("rst.data", 32'({data_in1, weight1_new}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run(tbl[i], i == 1, 1'b0, $sformatf("tbl%0d", i));

        // Stray neuron_done while idle must not start anything.
        @(negedge clk); neuron_done = 1'b1;
        @(negedge clk); neuron_done = 1'b0;
        chk("stray_done.busy", 32'(busy), 32'd0);

        run(tbl[3], 1'b0, 1'b1, "clr_coincident");
        run(tbl[1], 1'b0, 1'b0, "after_clr");

        for (int i = 0; i < 30; i++) begin
            v = mk(16'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), int'($urandom_range(0, 5)), $urandom_range(0, 9) != 0, 0, 0, 0, 0);
            run(model(v), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $sformatf("rnd%0d", i));
        end

        // Reset while waiting for the neuron.
        run(tbl[1], 1'b0, 1'b0, "pre_reset");
        @(negedge clk);
        x1 = 16'h0300; x2 = 16'h0100; target = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.strobes", 32'({input_write, neuron_start, weight_write, done, error, timeout}), 32'd0);
        chk("midrst.err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst.data", 32'({data_in1, data_in2}), 32'd0);
        chk("midrst.wnew", 32'({weight1_new, weight2_new}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < TMO + 10; c++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("midrst.quiet", 32'(dones), 32'd0);
        run(tbl[2], 1'b0, 1'b0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
